// File: rtl/jt051937_pkg.sv
// rtl/jt051937_pkg.sv - shared types and constants for the 051937 sprite line drawer
//
// Purpose: FSM state type, zoom scale constants and the line-buffer pixel layout
// shared by jt051937_draw and jt051937_lbuf.
// Ports: none (package).
package jt051937_pkg;

  // hzoom value for 1:1 scale; its log2 is the number of fractional zoom bits
  localparam logic [9:0] HZ_ONE = 10'h40;
  localparam int         FRAC_W = $clog2(HZ_ONE);
  localparam int         LB_AW  = 9;

  typedef enum logic [1:0] {IDLE, FETCH0, FETCH1, DRAW} draw_st_t;

  // 0 in every field means transparent / erased
  typedef struct packed {
    logic [1:0] shd;
    logic [9:0] attr;
    logic [3:0] pix;
  } lb_pxl_t;

endpackage

// File: rtl/jt051937_lbuf.sv
// rtl/jt051937_lbuf.sv - ping-pong double line buffer with read-and-erase display port
//
// Purpose: two 512x16 lines. One is written by the drawer while the other is streamed
// to the mixer and erased behind the read. swap exchanges the two roles.
// Ports:
//   rst, clk   asynchronous active-high reset, clock
//   swap       one-cycle pulse exchanging write/read lines (wins over a same-cycle write)
//   we, waddr, wdata   draw-side write port
//   pxl_cen, raddr     display-side read-and-erase strobe and address
//   rdata              registered read data, updated on pxl_cen
module jt051937_lbuf
  import jt051937_pkg::*;
(
  input  logic             rst,
  input  logic             clk,
  input  logic             swap,
  input  logic             we,
  input  logic [LB_AW-1:0] waddr,
  input  lb_pxl_t          wdata,
  input  logic             pxl_cen,
  input  logic [LB_AW-1:0] raddr,
  output lb_pxl_t          rdata
);

  localparam int DEPTH = 1 << LB_AW;

  lb_pxl_t mem0 [0:DEPTH-1];
  lb_pxl_t mem1 [0:DEPTH-1];
  logic    sel;   // line currently being written; the other one is displayed
  logic    wr;

  assign wr = we & ~swap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       sel <= 1'b0;
    else if (swap) sel <= ~sel;
  end

  // Write and erase always target different lines, so one port per line suffices
  always_ff @(posedge clk) begin
    if (wr && !sel)          mem0[waddr] <= wdata;
    else if (pxl_cen && sel) mem0[raddr] <= '0;
  end

  always_ff @(posedge clk) begin
    if (wr && sel)            mem1[waddr] <= wdata;
    else if (pxl_cen && !sel) mem1[raddr] <= '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rdata <= '0;
    else if (pxl_cen) rdata <= sel ? mem0[raddr] : mem1[raddr];
  end

endmodule

// File: rtl/jt051937_draw.sv
// rtl/jt051937_draw.sv - sprite line drawer answering the 053246 dr_start/dr_busy handshake
//
// Purpose: latch one 16-pixel tile slice, fetch its two ROM words, draw it with
// horizontal zoom/flip into the line buffer, and stream the previous line out.
// Ports:
//   rst, clk          asynchronous active-high reset, clock
//   pxl_cen           pixel clock enable for the read side
//   hs                horizontal sync; rising edge swaps lines and aborts a draw
//   dr_start/dr_busy  draw request / busy handshake
//   code, attr, shd, hflip, vflip, hpos, ysub, hzoom, hz_keep   tile slice description
//   rom_addr, rom_cs, rom_data, rom_ok   object ROM, 32-bit words
//   hdump, pxl        display read address and {shd,attr,pix} output
module jt051937_draw
  import jt051937_pkg::*;
(
  input  logic        rst,
  input  logic        clk,
  input  logic        pxl_cen,
  input  logic        hs,
  input  logic        dr_start,
  output logic        dr_busy,
  input  logic [15:0] code,
  input  logic [9:0]  attr,
  input  logic [1:0]  shd,
  input  logic        hflip,
  input  logic        vflip,
  input  logic [8:0]  hpos,
  input  logic [3:0]  ysub,
  input  logic [11:0] hzoom,
  input  logic        hz_keep,
  output logic [20:0] rom_addr,
  output logic        rom_cs,
  input  logic [31:0] rom_data,
  input  logic        rom_ok,
  input  logic [8:0]  hdump,
  output logic [15:0] pxl
);

  draw_st_t    state, st_nx;
  logic        hs_l, hs_rise;
  logic [15:0] code_l;
  logic [9:0]  attr_l;
  logic [1:0]  shd_l;
  logic        hflip_l, vflip_l;
  logic [3:0]  ysub_l;
  logic [9:0]  step;
  logic [31:0] word0, word1;
  logic [8:0]  x, x_end;
  logic [10:0] acc, acc_nx;
  logic [8:0]  cnt;
  logic [FRAC_W-1:0] frac;
  logic [3:0]  src, nib;
  logic [5:0]  nib_hi;
  logic [63:0] slice;
  logic        draw_end;
  logic        lb_we;
  lb_pxl_t     lb_data, rd_pxl;
  logic        zoom_unused;

  assign zoom_unused = ^hzoom[11:10];

  assign hs_rise = hs & ~hs_l;
  assign dr_busy = state != IDLE;

  // Source column from the integer part of the accumulator; pixel 0 is word0's top nibble
  assign src      = hflip_l ? ~acc[FRAC_W+3:FRAC_W] : acc[FRAC_W+3:FRAC_W];
  assign slice    = {word0, word1};
  assign nib_hi   = 6'd63 - {src, 2'b00};
  assign nib      = slice[nib_hi -: 4];
  assign acc_nx   = acc + {1'b0, step};
  assign draw_end = acc_nx[10] | (cnt == 9'h1FF);
  assign lb_data  = '{shd: shd_l, attr: attr_l, pix: nib};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= st_nx;
  end

  always_comb begin
    st_nx    = state;
    rom_cs   = 1'b0;
    rom_addr = '0;
    lb_we    = 1'b0;
    case (state)
      IDLE: if (dr_start) st_nx = FETCH0;
      FETCH0: begin
        rom_cs   = 1'b1;
        rom_addr = {code_l, ysub_l ^ {4{vflip_l}}, 1'b0};
        if (rom_ok) st_nx = FETCH1;
      end
      FETCH1: begin
        rom_cs   = 1'b1;
        rom_addr = {code_l, ysub_l ^ {4{vflip_l}}, 1'b1};
        if (rom_ok) st_nx = DRAW;
      end
      DRAW: begin
        lb_we = nib != 4'd0;
        if (draw_end) st_nx = IDLE;
      end
      default: st_nx = IDLE;
    endcase
    if (hs_rise && state != IDLE) st_nx = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_l    <= 1'b0;
      code_l  <= '0;
      attr_l  <= '0;
      shd_l   <= '0;
      hflip_l <= 1'b0;
      vflip_l <= 1'b0;
      ysub_l  <= '0;
      step    <= 10'd1;
      word0   <= '0;
      word1   <= '0;
      x       <= '0;
      x_end   <= '0;
      acc     <= '0;
      cnt     <= '0;
      frac    <= '0;
    end else begin
      hs_l <= hs;
      case (state)
        IDLE: if (dr_start) begin
          code_l  <= code;
          attr_l  <= attr;
          shd_l   <= shd;
          hflip_l <= hflip;
          vflip_l <= vflip;
          ysub_l  <= ysub;
          step    <= (hzoom[9:0] == 10'd0) ? 10'd1 : hzoom[9:0];
          cnt     <= '0;
          // Continuing tiles resume where the previous one stopped so zoomed tiles abut
          x       <= hz_keep ? x_end : hpos;
          acc     <= hz_keep ? {{(11-FRAC_W){1'b0}}, frac} : 11'd0;
        end
        FETCH0: if (rom_ok) word0 <= rom_data;
        FETCH1: if (rom_ok) word1 <= rom_data;
        DRAW: if (!hs_rise) begin
          x   <= x + 9'd1;
          acc <= acc_nx;
          cnt <= cnt + 9'd1;
          if (draw_end) begin
            x_end <= x + 9'd1;
            frac  <= acc_nx[FRAC_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  jt051937_lbuf u_lbuf (
    .rst     (rst),
    .clk     (clk),
    .swap    (hs_rise),
    .we      (lb_we),
    .waddr   (x),
    .wdata   (lb_data),
    .pxl_cen (pxl_cen),
    .raddr   (hdump),
    .rdata   (rd_pxl)
  );

  assign pxl = rd_pxl;

endmodule

// File: tb/tb_jt051937_draw.sv
// tb/tb_jt051937_draw.sv - directed self-checking bench for jt051937_draw
module tb_jt051937_draw;

  logic        rst, clk, pxl_cen, hs, dr_start, dr_busy;
  logic [15:0] code;
  logic [9:0]  attr;
  logic [1:0]  shd;
  logic        hflip, vflip, hz_keep;
  logic [8:0]  hpos, hdump;
  logic [3:0]  ysub;
  logic [11:0] hzoom;
  logic [20:0] rom_addr;
  logic        rom_cs, rom_ok;
  logic [31:0] rom_data;
  logic [15:0] pxl;

  jt051937_draw dut (
    .rst(rst), .clk(clk), .pxl_cen(pxl_cen), .hs(hs), .dr_start(dr_start), .dr_busy(dr_busy),
    .code(code), .attr(attr), .shd(shd), .hflip(hflip), .vflip(vflip), .hpos(hpos),
    .ysub(ysub), .hzoom(hzoom), .hz_keep(hz_keep), .rom_addr(rom_addr), .rom_cs(rom_cs),
    .rom_data(rom_data), .rom_ok(rom_ok), .hdump(hdump), .pxl(pxl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, t0 = 0, lat;
  always @(posedge clk) cyc <= cyc + 1;

  // ROM responder: rom_ok after rom_wait wait states per word
  logic [31:0] w0, w1;
  int rom_wait = 0, wcnt = 0;
  assign rom_ok   = rom_cs && (wcnt >= rom_wait);
  assign rom_data = rom_addr[0] ? w1 : w0;
  always @(posedge clk) wcnt <= (!rom_cs || rom_ok) ? 0 : wcnt + 1;

  // Activity monitor, sampled mid-cycle
  int nwr, nrom, first_wr, busy_rise, cs_cyc;
  logic [8:0]  first_wa;
  logic [20:0] rom_log [0:3];
  always @(negedge clk) begin
    if (!rst) begin
      if (dut.u_lbuf.wr) begin
        if (first_wr < 0) begin
          first_wr = cyc;
          first_wa = dut.u_lbuf.waddr;
        end
        nwr++;
      end
      if (rom_cs && rom_ok) begin
        if (nrom < 4) rom_log[nrom] = rom_addr;
        nrom++;
      end
      if (rom_cs) cs_cyc++;
      if (dr_busy && busy_rise < 0) busy_rise = cyc;
    end
  end

  logic [15:0] exp_line [0:511];
  logic [15:0] v;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_mon;
    nwr = 0; nrom = 0; first_wr = -1; busy_rise = -1; cs_cyc = 0; first_wa = '0;
    for (int i = 0; i < 4; i++) rom_log[i] = '0;
  endtask

  task automatic pulse_start;
    dr_start = 1'b1;
    t0 = cyc;
    tick;
    dr_start = 1'b0;
  endtask

  task automatic wait_idle(output int l);
    int n = 0;
    while (dr_busy && n < 4000) begin
      tick;
      n++;
    end
    check("busy_timeout", dr_busy, 1'b0);
    l = cyc - t0;
  endtask

  task automatic swap;
    hs = 1'b1;
    tick;
    hs = 1'b0;
    tick;
  endtask

  task automatic rd(input logic [8:0] a, output logic [15:0] val);
    hdump = a;
    pxl_cen = 1'b1;
    tick;
    val = pxl;
    pxl_cen = 1'b0;
  endtask

  task automatic erase_line;
    logic [15:0] dummy;
    for (int i = 0; i < 512; i++) rd(9'(i), dummy);
  endtask

  // Full readout of the displayed line against exp_line; erases both as it goes
  task automatic check_line(input string name);
    logic [15:0] val;
    for (int i = 0; i < 512; i++) begin
      rd(9'(i), val);
      check($sformatf("%s[%0h]", name, i), val, exp_line[i]);
      exp_line[i] = '0;
    end
  endtask

  // Nibble of source column i for the pattern words 12345678 / 9abcdef7
  function automatic logic [3:0] nib(input int i);
    return (i < 15) ? 4'(i + 1) : 4'h7;
  endfunction

  initial begin
    rst = 1'b1; pxl_cen = 1'b0; hs = 1'b0; dr_start = 1'b0;
    code = '0; attr = '0; shd = '0; hflip = 1'b0; vflip = 1'b0; hpos = '0;
    ysub = '0; hzoom = '0; hz_keep = 1'b0; hdump = '0; w0 = '0; w1 = '0;
    for (int i = 0; i < 512; i++) exp_line[i] = '0;
    clr_mon;
    repeat (3) tick;
    check("rst_busy", dr_busy, 1'b0);
    check("rst_cs", rom_cs, 1'b0);
    check("rst_addr", rom_addr, 21'h0);
    check("rst_pxl", pxl, 16'h0);
    rst = 1'b0;
    tick;
    erase_line;
    swap;
    erase_line;

    // 1) 1:1 draw; address = {0123, 3, lsb} = 0x2466 / 0x2467
    w0 = 32'h12345678; w1 = 32'h9abcdef7;
    shd = 2'b01; attr = 10'h155; code = 16'h0123; ysub = 4'd3;
    hpos = 9'h040; hzoom = 12'h040;
    clr_mon; pulse_start; wait_idle(lat);
    check("t1_latency", lat, 19);
    check("t1_addr0", rom_log[0], 21'h002466);
    check("t1_addr1", rom_log[1], 21'h002467);
    check("t1_writes", nwr, 16);
    check("t1_first_wr", first_wr - busy_rise, 2);
    for (int i = 0; i < 16; i++) exp_line[9'h040 + i] = {2'b01, 10'h155, nib(i)};
    swap; check_line("t1");

    // 2) transparency + hflip; vflip makes ysub 3 -> c, address 0x2478
    w0 = 32'h10000000; w1 = 32'h0; hflip = 1'b1; vflip = 1'b1; hpos = 9'h100;
    clr_mon; pulse_start; wait_idle(lat);
    check("t2_addr0", rom_log[0], 21'h002478);
    check("t2_writes", nwr, 1);
    exp_line[9'h10F] = {2'b01, 10'h155, 4'h1};
    swap; check_line("t2");

    // 3a) shrink by 2: even source columns at 0x20..0x27
    w0 = 32'h12345678; w1 = 32'h9abcdef7; hflip = 1'b0; vflip = 1'b0;
    hpos = 9'h020; hzoom = 12'h080;
    clr_mon; pulse_start; wait_idle(lat);
    check("t3a_writes", nwr, 8);
    for (int k = 0; k < 8; k++) exp_line[9'h020 + k] = {2'b01, 10'h155, nib(2 * k)};
    swap; check_line("t3a");

    // 3b) enlarge by 2 at 0x80..0x9f, then 3c) continuation from x_end = 0xa0
    hpos = 9'h080; hzoom = 12'h020;
    clr_mon; pulse_start; wait_idle(lat);
    check("t3b_writes", nwr, 32);
    for (int j = 0; j < 32; j++) exp_line[9'h080 + j] = {2'b01, 10'h155, nib(j / 2)};
    hz_keep = 1'b1; hpos = 9'h010; hzoom = 12'h040;
    clr_mon; pulse_start; wait_idle(lat);
    check("t3c_writes", nwr, 16);
    check("t3c_first_addr", first_wa, 9'h0A0);
    for (int i = 0; i < 16; i++) exp_line[9'h0A0 + i] = {2'b01, 10'h155, nib(i)};
    hz_keep = 1'b0;
    swap; check_line("t3bc");

    // 4) five wait states per word; a second dr_start while busy is ignored
    rom_wait = 5; hpos = 9'h060;
    clr_mon; pulse_start;
    tick; tick;
    code = 16'h7777; dr_start = 1'b1; tick; dr_start = 1'b0;
    wait_idle(lat);
    check("t4_latency", lat, 29);
    check("t4_addr0", rom_log[0], 21'h002466);
    check("t4_addr1", rom_log[1], 21'h002467);
    check("t4_rom_acks", nrom, 2);
    check("t4_cs_cycles", cs_cyc, 12);
    check("t4_first_wr", first_wr - busy_rise, 12);
    check("t4_writes", nwr, 16);
    for (int i = 0; i < 16; i++) exp_line[9'h060 + i] = {2'b01, 10'h155, nib(i)};
    swap; check_line("t4");
    rom_wait = 0; code = 16'h0123;

    // 5) hs abort after 4 pixels; the hs edge itself performs the swap
    hpos = 9'h180;
    clr_mon; pulse_start;
    begin
      int n = 0;
      while (nwr < 4 && n < 100) begin
        tick;
        n++;
      end
    end
    hs = 1'b1; tick; hs = 1'b0;
    check("t5_busy", dr_busy, 1'b0);
    check("t5_cs", rom_cs, 1'b0);
    tick;
    check("t5_writes", nwr, 4);
    for (int i = 0; i < 4; i++) exp_line[9'h180 + i] = {2'b01, 10'h155, nib(i)};
    check_line("t5");
    for (int i = 0; i < 4; i++) begin
      rd(9'h180 + 9'(i), v);
      check("t5_erased", v, 16'h0);
    end

    // 5b) hs abort during FETCH0
    rom_wait = 5;
    clr_mon; pulse_start;
    check("t5b_cs_on", rom_cs, 1'b1);
    hs = 1'b1; tick; hs = 1'b0;
    check("t5b_cs", rom_cs, 1'b0);
    check("t5b_busy", dr_busy, 1'b0);
    check("t5b_acks", nrom, 0);
    rom_wait = 0;
    tick;

    // 6) x wraps from 0x1ff to 0x000
    hpos = 9'h1F8;
    clr_mon; pulse_start; wait_idle(lat);
    check("t6_writes", nwr, 16);
    for (int i = 0; i < 16; i++) exp_line[(9'h1F8 + 9'(i))] = {2'b01, 10'h155, nib(i)};
    swap; check_line("t6");

    // 6b) asynchronous reset in the middle of DRAW
    hpos = 9'h010;
    clr_mon; pulse_start;
    repeat (5) tick;
    check("t6b_drawing", dr_busy, 1'b1);
    #3 rst = 1'b1;
    #1;
    check("t6b_busy", dr_busy, 1'b0);
    check("t6b_cs", rom_cs, 1'b0);
    check("t6b_addr", rom_addr, 21'h0);
    check("t6b_pxl", pxl, 16'h0);
    tick;
    rst = 1'b0;
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
